// File: rtl/s1_decode_stage.sv
// -----------------------------------------------------------------------------
// s1_decode_stage
//
// Stage-1 -> stage-2 boundary of the pipelined datapath. It decodes the fetched
// instruction word, drives the register-file read addresses, and registers
// everything the stage-2 operand mux and ALU consume. Both sides use a
// valid/ready handshake. The block also supports a flush and keeps a saturating
// count of bubble cycles.
//
// Optional feature: define HAZARD_STALL_EN to enable the RAW interlock. This
// tracks the destination of the live stage-2 entry plus a WB_LAT-deep history
// of destinations already accepted downstream. S1_Ready is held low while the
// incoming instruction reads one of those registers.
//
// Parameters
//   WB_LAT  cycles between a stage-2 accept and register write-back
//   CNT_W   width of BubbleCount
//
// Ports
//   clk, reset                      clock, async active-high reset
//   S1_Instr/S1_Valid/S1_Ready      upstream instruction handshake
//   S1_ReadSelect1/2                register-file read addresses (rs, rt)
//   S1_ReadData1/2                  register-file read data (same cycle)
//   Flush                           kill the held stage-2 instruction
//   S2_Valid/S2_Ready               downstream handshake
//   S2_ReadData1/2, S2_Imm          registered operands and raw immediate
//   S2_DataSource                   1 = immediate operand, 0 = ReadData2
//   S2_ALUOp                        registered opcode[2:0]
//   S2_WriteEn/S2_WriteSelect       write-back enable and destination
//   BubbleCount                     saturating count of S2_Valid=0 cycles
// -----------------------------------------------------------------------------
module s1_decode_stage #(
  parameter int WB_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      S1_Instr,
  input  logic             S1_Valid,
  output logic             S1_Ready,
  output logic [4:0]       S1_ReadSelect1,
  output logic [4:0]       S1_ReadSelect2,
  input  logic [31:0]      S1_ReadData1,
  input  logic [31:0]      S1_ReadData2,
  input  logic             Flush,
  output logic             S2_Valid,
  input  logic             S2_Ready,
  output logic [31:0]      S2_ReadData1,
  output logic [31:0]      S2_ReadData2,
  output logic [15:0]      S2_Imm,
  output logic             S2_DataSource,
  output logic [2:0]       S2_ALUOp,
  output logic             S2_WriteEn,
  output logic [4:0]       S2_WriteSelect,
  output logic [CNT_W-1:0] BubbleCount
);

  logic [5:0]       opcode;
  logic             dec_data_source;
  logic             dec_write_en;
  logic [4:0]       dec_write_select;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_read_data1_q, s2_read_data1_d;
  logic [31:0]      s2_read_data2_q, s2_read_data2_d;
  logic [15:0]      s2_imm_q, s2_imm_d;
  logic             s2_data_source_q, s2_data_source_d;
  logic [2:0]       s2_alu_op_q, s2_alu_op_d;
  logic             s2_write_en_q, s2_write_en_d;
  logic [4:0]       s2_write_select_q, s2_write_select_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic             hazard_stall;
  logic             s1_ready;
  logic             take;
  logic             fire;
  logic             unused_opcode_bit;

  assign opcode            = S1_Instr[31:26];
  assign unused_opcode_bit = opcode[3];
  assign S1_ReadSelect1    = S1_Instr[25:21];
  assign S1_ReadSelect2    = S1_Instr[20:16];

  // Instruction decode; r0 as destination suppresses the write entirely.
  always_comb begin
    dec_data_source  = 1'b0;
    dec_write_en     = 1'b0;
    dec_write_select = 5'd0;
    case (opcode[5:4])
      2'b01: begin
        dec_write_en     = 1'b1;
        dec_write_select = S1_Instr[15:11];
      end
      2'b11: begin
        dec_data_source  = 1'b1;
        dec_write_en     = 1'b1;
        dec_write_select = S1_Instr[20:16];
      end
      default: ;
    endcase
    if (dec_write_select == 5'd0) dec_write_en = 1'b0;
  end

`ifdef HAZARD_STALL_EN
  logic [WB_LAT-1:0][4:0] wb_dest_q, wb_dest_d;
  logic [4:0]             live_dest;
  logic                   uses_rt;

  // A live entry only counts as a pending write when it will actually write.
  assign live_dest = (s2_valid_q && s2_write_en_q) ? s2_write_select_q : 5'd0;
  assign uses_rt   = (opcode[5:4] == 2'b01);

  // Write-back history advances every cycle; a slot is filled only by a fire.
  always_comb begin
    wb_dest_d = wb_dest_q;
    for (int i = WB_LAT - 1; i > 0; i--) wb_dest_d[i] = wb_dest_q[i-1];
    wb_dest_d[0] = fire ? live_dest : 5'd0;
  end

  // rs is always a source; rt is a source only for R-type (I-type writes it).
  always_comb begin
    hazard_stall = 1'b0;
    if (live_dest != 5'd0 &&
        (live_dest == S1_Instr[25:21] || (uses_rt && live_dest == S1_Instr[20:16])))
      hazard_stall = 1'b1;
    for (int i = 0; i < WB_LAT; i++) begin
      if (wb_dest_q[i] != 5'd0 &&
          (wb_dest_q[i] == S1_Instr[25:21] || (uses_rt && wb_dest_q[i] == S1_Instr[20:16])))
        hazard_stall = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_dest_q <= '0;
    else       wb_dest_q <= wb_dest_d;
  end
`else
  assign hazard_stall = 1'b0;
`endif

  // Flush blocks acceptance so a same-cycle transfer is discarded too.
  assign s1_ready = (~s2_valid_q | S2_Ready) & ~Flush & ~hazard_stall;
  assign take     = S1_Valid & s1_ready;
  assign fire     = s2_valid_q & S2_Ready;

  // Stage-2 register update: data loads only on a transfer and otherwise holds.
  always_comb begin
    s2_read_data1_d   = s2_read_data1_q;
    s2_read_data2_d   = s2_read_data2_q;
    s2_imm_d          = s2_imm_q;
    s2_data_source_d  = s2_data_source_q;
    s2_alu_op_d       = s2_alu_op_q;
    s2_write_en_d     = s2_write_en_q;
    s2_write_select_d = s2_write_select_q;
    s2_valid_d        = s2_valid_q;
    if (take) begin
      s2_read_data1_d   = S1_ReadData1;
      s2_read_data2_d   = S1_ReadData2;
      s2_imm_d          = S1_Instr[15:0];
      s2_data_source_d  = dec_data_source;
      s2_alu_op_d       = opcode[2:0];
      s2_write_en_d     = dec_write_en;
      s2_write_select_d = dec_write_select;
    end
    if (Flush)     s2_valid_d = 1'b0;
    else if (take) s2_valid_d = 1'b1;
    else if (fire) s2_valid_d = 1'b0;
  end

  // Bubble counter saturates at all-ones.
  always_comb begin
    bubble_d = bubble_q;
    if (!s2_valid_q && bubble_q != {CNT_W{1'b1}}) bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q        <= 1'b0;
      s2_read_data1_q   <= '0;
      s2_read_data2_q   <= '0;
      s2_imm_q          <= '0;
      s2_data_source_q  <= 1'b0;
      s2_alu_op_q       <= '0;
      s2_write_en_q     <= 1'b0;
      s2_write_select_q <= '0;
      bubble_q          <= '0;
    end else begin
      s2_valid_q        <= s2_valid_d;
      s2_read_data1_q   <= s2_read_data1_d;
      s2_read_data2_q   <= s2_read_data2_d;
      s2_imm_q          <= s2_imm_d;
      s2_data_source_q  <= s2_data_source_d;
      s2_alu_op_q       <= s2_alu_op_d;
      s2_write_en_q     <= s2_write_en_d;
      s2_write_select_q <= s2_write_select_d;
      bubble_q          <= bubble_d;
    end
  end

  assign S1_Ready       = s1_ready;
  assign S2_Valid       = s2_valid_q;
  assign S2_ReadData1   = s2_read_data1_q;
  assign S2_ReadData2   = s2_read_data2_q;
  assign S2_Imm         = s2_imm_q;
  assign S2_DataSource  = s2_data_source_q;
  assign S2_ALUOp       = s2_alu_op_q;
  assign S2_WriteEn     = s2_write_en_q;
  assign S2_WriteSelect = s2_write_select_q;
  assign BubbleCount    = bubble_q;

endmodule
